// File: rtl/param_element_search_if.sv
// Purpose : bundle of search request/result signals between controller and engine.
// Latency : none, wires only.
// Backpressure: start/ack handshake. start is sampled only while idle, ack only while done.
// Ports   : start, ack, mode, key, data_in (controller -> engine);
//           busy, done, found, location, value, cycles (engine -> controller).
interface param_element_search_if #(
  parameter int N    = 10,
  parameter int W    = 7,
  parameter int IDXW = 4,
  parameter int CNTW = 8
);
  logic            start;
  logic            ack;
  logic [1:0]      mode;
  logic [W-1:0]    key;
  logic [N*W-1:0]  data_in;
  logic            busy;
  logic            done;
  logic            found;
  logic [IDXW-1:0] location;
  logic [W-1:0]    value;
  logic [CNTW-1:0] cycles;

  modport master (
    output start, ack, mode, key, data_in,
    input  busy, done, found, location, value, cycles
  );

  modport slave (
    input  start, ack, mode, key, data_in,
    output busy, done, found, location, value, cycles
  );
endinterface

// File: rtl/param_element_search.sv
// Purpose : sequential max/min/first-match/last-match search over an N x W-bit array.
// Latency : N scan cycles after the capture edge, or k+1 on an early first-match at index k.
// Backpressure: start is taken only in IDLE. The result holds in DONE until ack, then stays visible in IDLE.
// Ports   : clk, reset (async, active-high), bus (slave side of param_element_search_if).
module param_element_search #(
  parameter int N    = 10,
  parameter int W    = 7,
  parameter int IDXW = 4,
  parameter int CNTW = 8
) (
  input logic                  clk,
  input logic                  reset,
  param_element_search_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [1:0] MODE_MAX   = 2'b00;
  localparam logic [1:0] MODE_MIN   = 2'b01;
  localparam logic [1:0] MODE_FIRST = 2'b10;
  localparam logic [1:0] MODE_LAST  = 2'b11;

  // Search request captured together with the array at the start edge.
  typedef struct packed {
    logic [1:0]   mode;
    logic [W-1:0] key;
  } req_t;

  state_t          state, state_nxt;
  req_t            req;
  logic [W-1:0]    arr [N];
  logic [IDXW-1:0] idx;
  logic [CNTW-1:0] cycles;
  logic            found;
  logic [IDXW-1:0] location;
  logic [W-1:0]    value;

  logic [W-1:0]    elem;
  logic            is_last;
  logic            is_eq;
  logic            take;
  logic            early;
  logic            capture;

  // Element under examination. The mux is built by comparison so the index
  // width never has to match the array depth.
  always_comb begin
    elem = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDXW'(i)) elem = arr[i];
    end
  end

  always_comb begin
    is_last = (idx == IDXW'(N - 1));
    is_eq   = (elem == req.key);
    // value doubles as the running best in max/min modes. idx 0 always seeds it.
    case (req.mode)
      MODE_MAX:   take = (idx == '0) || (elem > value);
      MODE_MIN:   take = (idx == '0) || (elem < value);
      MODE_FIRST: take = is_eq;
      MODE_LAST:  take = is_eq;
      default:    take = 1'b0;
    endcase
    early   = (req.mode == MODE_FIRST) && is_eq;
    capture = (state == IDLE) && bus.start;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SCAN;
      SCAN:    if (is_last || early) state_nxt = DONE;
      DONE:    if (bus.ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath: capture in IDLE, one element per cycle in SCAN, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) arr[i] <= '0;
      req      <= '0;
      idx      <= '0;
      cycles   <= '0;
      found    <= 1'b0;
      location <= '0;
      value    <= '0;
    end else if (capture) begin
      for (int i = 0; i < N; i++) arr[i] <= bus.data_in[i*W +: W];
      req.mode <= bus.mode;
      req.key  <= bus.key;
      idx      <= '0;
      cycles   <= '0;
      found    <= 1'b0;
      location <= '0;
      value    <= '0;
    end else if (state == SCAN) begin
      idx <= idx + IDXW'(1);
      if (cycles != '1) cycles <= cycles + CNTW'(1);
      if (take) begin
        found    <= 1'b1;
        location <= idx;
        value    <= elem;
      end
    end
  end

  assign bus.busy     = (state == SCAN);
  assign bus.done     = (state == DONE);
  assign bus.found    = found;
  assign bus.location = location;
  assign bus.value    = value;
  assign bus.cycles   = cycles;

endmodule

// File: tb/tb_param_element_search.sv
// Purpose : directed self-checking bench for param_element_search (N=10/W=7 and N=1/W=16).
// Latency : done is expected N cycles after the capture edge, or k+1 on a first match at k.
// Backpressure: ack is driven by the bench; the result must hold while ack stays low.
module tb_param_element_search;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  param_element_search_if #(.N(10), .W(7),  .IDXW(4), .CNTW(8)) b0 ();
  param_element_search_if #(.N(1),  .W(16), .IDXW(1), .CNTW(8)) b1 ();

  param_element_search #(.N(10), .W(7), .IDXW(4), .CNTW(8)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0.slave)
  );

  param_element_search #(.N(1), .W(16), .IDXW(1), .CNTW(8)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load0(input int v[10]);
    for (int i = 0; i < 10; i++) b0.data_in[i*7 +: 7] = v[i][6:0];
  endtask

  // Wait (bounded) for done on DUT0, counting edges since the capture edge.
  task automatic wait_done0(inout int lat);
    while (!b0.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run0(input logic [1:0] m, input logic [6:0] k, output int lat);
    @(negedge clk);
    b0.mode  = m;
    b0.key   = k;
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    lat = 0;
    wait_done0(lat);
  endtask

  task automatic ack0();
    @(negedge clk);
    b0.ack = 1'b1;
    @(negedge clk);
    b0.ack = 1'b0;
  endtask

  task automatic run1(input logic [1:0] m, input logic [15:0] k, output int lat);
    @(negedge clk);
    b1.mode  = m;
    b1.key   = k;
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    lat = 0;
    while (!b1.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int va[10];
    int vb[10];
    int vc[10];

    va = '{3, 9, 12, 12, 5, 0, 127, 127, 1, 2};
    vb = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    vc = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100};

    b0.start = 1'b0; b0.ack = 1'b0; b0.mode = 2'b00; b0.key = '0; b0.data_in = '0;
    b1.start = 1'b0; b1.ack = 1'b0; b1.mode = 2'b00; b1.key = '0; b1.data_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",   b0.busy,     0);
    check("rst_done",   b0.done,     0);
    check("rst_found",  b0.found,    0);
    check("rst_loc",    b0.location, 0);
    check("rst_value",  b0.value,    0);
    check("rst_cycles", b0.cycles,   0);
    reset = 1'b0;

    // Max
    load0(va);
    run0(2'b00, 7'd0, lat);
    check("max_lat",   lat,         10);
    check("max_busy",  b0.busy,     0);
    check("max_found", b0.found,    1);
    check("max_loc",   b0.location, 6);
    check("max_value", b0.value,    127);
    check("max_cyc",   b0.cycles,   10);
    ack0();
    check("max_ack_done", b0.done, 0);

    // Min
    run0(2'b01, 7'd0, lat);
    check("min_lat",   lat,         10);
    check("min_loc",   b0.location, 5);
    check("min_value", b0.value,    0);
    check("min_cyc",   b0.cycles,   10);
    ack0();

    // First match, early exit at index 2
    run0(2'b10, 7'd12, lat);
    check("first_lat",   lat,         3);
    check("first_found", b0.found,    1);
    check("first_loc",   b0.location, 2);
    check("first_value", b0.value,    12);
    check("first_cyc",   b0.cycles,   3);
    ack0();

    // Last match
    run0(2'b11, 7'd12, lat);
    check("last_lat",   lat,         10);
    check("last_found", b0.found,    1);
    check("last_loc",   b0.location, 3);
    check("last_value", b0.value,    12);
    check("last_cyc",   b0.cycles,   10);
    ack0();

    // Absent key
    run0(2'b10, 7'd100, lat);
    check("miss_lat",   lat,         10);
    check("miss_found", b0.found,    0);
    check("miss_loc",   b0.location, 0);
    check("miss_value", b0.value,    0);
    check("miss_cyc",   b0.cycles,   10);
    ack0();

    // Handshake: start, data and mode changes during SCAN are ignored
    @(negedge clk);
    b0.mode = 2'b00; b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    repeat (2) @(negedge clk);
    b0.start = 1'b1; b0.data_in = '0; b0.mode = 2'b01;
    @(negedge clk);
    b0.start = 1'b0;
    check("hs_busy", b0.busy, 1);
    lat = 3;
    wait_done0(lat);
    check("hs_lat",   lat,         10);
    check("hs_loc",   b0.location, 6);
    check("hs_value", b0.value,    127);
    // ack held low: DONE and result hold
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hs_hold_done", b0.done,     1);
      check("hs_hold_loc",  b0.location, 6);
    end
    // ack and start together in DONE: ack wins, start is ignored
    b0.ack = 1'b1; b0.start = 1'b1;
    load0(vc); b0.mode = 2'b01;
    @(negedge clk);
    b0.ack = 1'b0;
    check("hs_idle_done", b0.done,     0);
    check("hs_idle_busy", b0.busy,     0);
    check("hs_keep_loc",  b0.location, 6);
    check("hs_keep_val",  b0.value,    127);
    check("hs_keep_fnd",  b0.found,    1);
    // start still high in IDLE: captured on this edge, result cleared
    @(negedge clk);
    b0.start = 1'b0;
    check("cap_busy",  b0.busy,     1);
    check("cap_found", b0.found,    0);
    check("cap_loc",   b0.location, 0);
    check("cap_value", b0.value,    0);
    check("cap_cyc",   b0.cycles,   0);
    lat = 0;
    wait_done0(lat);
    check("new_lat",   lat,      10);
    check("new_value", b0.value, 10);
    ack0();

    // Reset in the middle of SCAN
    load0(va);
    @(negedge clk);
    b0.mode = 2'b00; b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", b0.busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy",  b0.busy,     0);
    check("mid_rst_found", b0.found,    0);
    check("mid_rst_loc",   b0.location, 0);
    check("mid_rst_value", b0.value,    0);
    check("mid_rst_cyc",   b0.cycles,   0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_done", b0.done, 0);
    check("post_rst_busy", b0.busy, 0);
    load0(vb);
    run0(2'b00, 7'd0, lat);
    check("seq_lat",   lat,         10);
    check("seq_loc",   b0.location, 9);
    check("seq_value", b0.value,    9);
    ack0();

    // N=1 instance
    b1.data_in = 16'hBEEF;
    run1(2'b00, 16'h0, lat);
    check("n1_lat",   lat,         1);
    check("n1_cyc",   b1.cycles,   1);
    check("n1_found", b1.found,    1);
    check("n1_loc",   b1.location, 0);
    check("n1_value", b1.value,    32'hBEEF);
    @(negedge clk);
    b1.ack = 1'b1;
    @(negedge clk);
    b1.ack = 1'b0;
    run1(2'b10, 16'h1234, lat);
    check("n1_miss_cyc",   b1.cycles, 1);
    check("n1_miss_found", b1.found,  0);
    check("n1_miss_value", b1.value,  0);
    @(negedge clk);
    b1.ack = 1'b1;
    @(negedge clk);
    b1.ack = 1'b0;
    run1(2'b10, 16'hBEEF, lat);
    check("n1_hit_lat",   lat,      1);
    check("n1_hit_found", b1.found, 1);
    check("n1_hit_value", b1.value, 32'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
